// File: rtl/fast_counter_pkg.sv
// Shared definitions for the sliced down-counter: mode encodings and the slice-count helper.
package fast_counter_pkg;

    localparam logic MODE_AUTORELOAD = 1'b0;
    localparam logic MODE_ONESHOT    = 1'b1;

    function automatic int calc_nstages(input int nbits, input int nbits_stage);
        return (nbits + nbits_stage - 1) / nbits_stage;
    endfunction

endpackage

// File: rtl/fast_counter_stage.sv
// One slice of the down-counter: holds its part of q and of the reload value,
// plus a registered flag telling whether the slice is currently zero.
module fast_counter_stage #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         reload,
    input  logic         dec,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] q,
    output logic         zero,
    output logic         zero_nxt
);

    logic [W-1:0] r_p1;
    logic [W-1:0] q_nxt;

    // A decrementing slice sitting at zero wraps to all ones, which is the borrow
    // into the slice above; the top only enables it when the lower slices are all zero.
    always_comb begin
        q_nxt = q;
        if (load)
            q_nxt = load_val;
        else if (reload)
            q_nxt = r_p1;
        else if (dec)
            q_nxt = q - W'(1);
    end

    assign zero_nxt = (q_nxt == '0);

    // Stage boundary: slice value, reload value and zero flag
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q    <= '0;
            r_p1 <= '0;
            zero <= 1'b1;
        end else begin
            q    <= q_nxt;
            zero <= zero_nxt;
            if (load)
                r_p1 <= load_val;
        end
    end

endmodule

// File: rtl/fast_counter.sv
// Pipelined down-counter built from NBITS_STAGE-bit slices (auto-reload or one-shot).
// Define FAST_COUNTER_CARRY_REG_EN to register o_carry (one cycle later, glitch-free).
module fast_counter
    import fast_counter_pkg::*;
#(
    parameter int NBITS       = 16,
    parameter int NBITS_STAGE = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_mode,
    input  logic             i_en,
    input  logic             i_load,
    input  logic [NBITS-1:0] i_load_q,
    output logic             o_zero,
    output logic             o_nzero,
    output logic             o_carry,
    output logic             o_zpulse,
    output logic [NBITS-1:0] o_q
);

    localparam int NSTAGES = calc_nstages(NBITS, NBITS_STAGE);

    logic [NSTAGES-1:0] zflag;
    logic [NSTAGES-1:0] zflag_nxt;
    logic [NSTAGES-1:0] lower_zero;
    logic [NSTAGES-1:0] dec;
    logic               q_zero;
    logic               counting;
    logic               reload_all;
    logic               carry_nxt;
    logic               zpulse_p1;

    assign q_zero     = &zflag;
    assign counting   = i_en & ~i_load;
    assign reload_all = counting & q_zero & (i_mode == MODE_AUTORELOAD);
    assign carry_nxt  = counting & q_zero;

    // Borrow is taken from the registered slice flags, so no carry chain spans slices.
    always_comb begin
        lower_zero    = '0;
        lower_zero[0] = 1'b1;
        for (int k = 1; k < NSTAGES; k++)
            lower_zero[k] = lower_zero[k-1] & zflag[k-1];
    end

    assign dec = {NSTAGES{counting & ~q_zero}} & lower_zero;

    for (genvar k = 0; k < NSTAGES; k++) begin : g_stage
        localparam int LO = k * NBITS_STAGE;
        localparam int W  = (k == NSTAGES - 1) ? (NBITS - LO) : NBITS_STAGE;

        fast_counter_stage #(
            .W(W)
        ) u_stage (
            .clk      (i_clk),
            .rst_n    (i_rst_n),
            .load     (i_load),
            .reload   (reload_all),
            .dec      (dec[k]),
            .load_val (i_load_q[LO +: W]),
            .q        (o_q[LO +: W]),
            .zero     (zflag[k]),
            .zero_nxt (zflag_nxt[k])
        );
    end

    // Stage boundary: zero pulse, raised only by a counted 1 -> 0 step
    always_ff @(posedge i_clk) begin
        if (!i_rst_n)
            zpulse_p1 <= 1'b0;
        else
            zpulse_p1 <= counting & ~q_zero & (&zflag_nxt);
    end

`ifdef FAST_COUNTER_CARRY_REG_EN
    logic carry_p1;

    // Stage boundary: terminal-count strobe, delayed one cycle
    always_ff @(posedge i_clk) begin
        if (!i_rst_n)
            carry_p1 <= 1'b0;
        else
            carry_p1 <= carry_nxt;
    end

    assign o_carry = carry_p1;
`else
    assign o_carry = carry_nxt;
`endif

    assign o_zero   = q_zero;
    assign o_nzero  = ~q_zero;
    assign o_zpulse = zpulse_p1;

endmodule

// File: tb/tb_fast_counter.sv
// Scoreboard bench for fast_counter (9-bit counter, 4-bit slices): directed scenarios plus random traffic.
module tb_fast_counter;

    localparam int NB = 9;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          mode = 1'b0;
    logic          en = 1'b0;
    logic          load = 1'b0;
    logic [NB-1:0] load_q = '0;
    logic          zero, nzero, carry, zpulse;
    logic [NB-1:0] q;

    fast_counter #(.NBITS(NB), .NBITS_STAGE(4)) dut (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_mode   (mode),
        .i_en     (en),
        .i_load   (load),
        .i_load_q (load_q),
        .o_zero   (zero),
        .o_nzero  (nzero),
        .o_carry  (carry),
        .o_zpulse (zpulse),
        .o_q      (q)
    );

    always #5 clk = ~clk;

    typedef struct {
        int q;
        bit zero;
        bit nzero;
        bit carry;
        bit zpulse;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   carry_seen = 0;
    int   zpulse_seen = 0;

    // reference model state
    int   mq = 0;
    int   mr = 0;
    bit   mzp = 0;
    bit   mcr = 0;
    bit   mvalid = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s act=%0d exp=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input bit r, input bit m, input bit e, input bit l, input int v);
        exp_t x;
        @(posedge clk);
        #1;
        rst_n  = r;
        mode   = m;
        en     = e;
        load   = l;
        load_q = v[NB-1:0];
        if (mvalid) begin
            x.q      = mq;
            x.zero   = (mq == 0);
            x.nzero  = (mq != 0);
            x.zpulse = mzp;
`ifdef FAST_COUNTER_CARRY_REG_EN
            x.carry  = mcr;
`else
            x.carry  = e && !l && (mq == 0);
`endif
            sb.push_back(x);
        end
        if (!r) begin
            mq = 0; mr = 0; mzp = 0; mcr = 0;
        end else begin
            mcr = e && !l && (mq == 0);
            mzp = 0;
            if (l) begin
                mq = v % (1 << NB);
                mr = mq;
            end else if (e) begin
                if (mq != 0) begin
                    mzp = (mq == 1);
                    mq  = mq - 1;
                end else if (m == 1'b0) begin
                    mq = mr;
                end
            end
        end
        mvalid = 1;
    endtask

    always @(negedge clk) begin
        exp_t x;
        if (sb.size() != 0) begin
            x = sb.pop_front();
            chk("q", int'(q), x.q);
            chk("zero", int'(zero), int'(x.zero));
            chk("nzero", int'(nzero), int'(x.nzero));
            chk("carry", int'(carry), int'(x.carry));
            chk("zpulse", int'(zpulse), int'(x.zpulse));
            if (carry === 1'b1) carry_seen++;
            if (zpulse === 1'b1) zpulse_seen++;
        end
    end

    initial begin
        int v, sel;
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);

        // auto-reload 0x33, enable every other cycle: 4 carries and 4 zpulses in 208 enables
        step(1, 0, 0, 1, 'h33);
        carry_seen = 0;
        zpulse_seen = 0;
        for (int i = 0; i < 416; i++) step(1, 0, (i % 2) == 0, 0, 0);
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        @(negedge clk);
        #1;
        chk("carry_count_0x33", carry_seen, 4);
        chk("zpulse_count_0x33", zpulse_seen, 4);

        // auto-reload with R = 1, then R = 0 (zpulse must stay low)
        step(1, 0, 0, 1, 1);
        for (int i = 0; i < 10; i++) step(1, 0, 1, 0, 0);
        step(1, 0, 0, 1, 0);
        zpulse_seen = 0;
        for (int i = 0; i < 10; i++) step(1, 0, 1, 0, 0);
        step(1, 0, 0, 0, 0);
        @(negedge clk);
        #1;
        chk("zpulse_count_r0", zpulse_seen, 0);

        // one-shot 0x3F, alternate enables, then extra enables at zero
        step(1, 1, 0, 1, 'h3F);
        for (int i = 0; i < 126; i++) step(1, 1, (i % 2) == 0, 0, 0);
        for (int i = 0; i < 6; i++) step(1, 1, 1, 0, 0);

        // one-shot 5: single load, then load held for 10 cycles with enable high
        step(1, 1, 0, 1, 5);
        for (int i = 0; i < 7; i++) step(1, 1, 1, 0, 0);
        for (int i = 0; i < 10; i++) step(1, 1, 1, 1, 5);
        for (int i = 0; i < 7; i++) step(1, 1, 1, 0, 0);

        // one-shot load 0, then borrow across slices 0x100 -> 0xFF
        step(1, 1, 0, 1, 0);
        for (int i = 0; i < 3; i++) step(1, 1, 1, 0, 0);
        step(1, 1, 0, 1, 'h100);
        step(1, 1, 1, 0, 0);
        step(1, 1, 0, 0, 0);
        step(1, 0, 1, 1, 'h1F0);
        for (int i = 0; i < 20; i++) step(1, 0, 1, 0, 0);

        // random traffic with occasional reset and mode flips
        for (int i = 0; i < 1500; i++) begin
            sel = $urandom_range(0, 5);
            case (sel)
                0: v = 0;
                1: v = 1;
                2: v = 'h100;
                3: v = $urandom_range(0, 7);
                default: v = $urandom_range(0, (1 << NB) - 1);
            endcase
            step($urandom_range(0, 199) != 0,
                 $urandom_range(0, 15) == 0 ? ~mode : mode,
                 $urandom_range(0, 3) != 0,
                 $urandom_range(0, 24) == 0,
                 v);
        end

        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        @(negedge clk);
        #1;
        chk("sb_drain", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fast_counter.md
Name: fast_counter

Overview:
- Pipelined, parameterizable down-counter for timing and prescaler use.
- Split internally into NBITS_STAGE-bit slices so the critical path is independent of NBITS.
- Two modes:
  - auto-reload: a periodic divider with period = reload+1 enabled cycles.
  - one-shot: a retriggerable timer that stops at zero.
- Sits between control-register logic and timing consumers (strobes, timeouts).

Parameters:
- NBITS, 16, total counter width (>=1).
- NBITS_STAGE, 4, slice width; NSTAGES = ceil(NBITS/NBITS_STAGE); the last slice may be narrower.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  reset: synchronous, active-low.
- i_mode  in  1  0 = auto-reload, 1 = one-shot; sampled every cycle.
- i_en  in  1  count enable; decrements only when high.
- i_load  in  1  load strobe; level-sensitive.
- i_load_q  in  NBITS  load/reload value.
- o_zero  out  1  q == 0.
- o_nzero  out  1  ~o_zero.
- o_carry  out  1  terminal-count strobe.
- o_zpulse  out  1  one-cycle pulse when q reaches 0 by counting.
- o_q  out  NBITS  current count.

Behaviour:
- Reset state (i_rst_n low at a clock edge):
  - q = 0, reload register R = 0.
  - o_zero = 1, o_nzero = 0, o_carry = 0, o_zpulse = 0.
- Priority per cycle: reset > load > enable.
- Load (i_load = 1): q <= i_load_q and R <= i_load_q, in both modes.
  - No decrement that cycle.
  - Holding i_load high holds q at i_load_q and suppresses counting.
- Enable with q != 0: q <= q-1.
- Enable with q == 0:
  - Auto-reload: q <= R.
  - One-shot: q stays 0 (stopped).
- o_carry = i_en & ~i_load & (q == 0).
  - Combinational from registered flags; asserted in both modes.
  - Auto-reload: one strobe per R+1 enables.
  - R == 0: strobe on every enable.
- o_zpulse: registered; high for exactly the first cycle q == 0 following an enabled 1->0 decrement.
  - Not raised by reset, by loading 0, or by a reload of 0.
- o_zero and o_nzero are registered flags, updated coherently with q (zero-latency relative to o_q).
- Mode change takes effect on the next enabled cycle.
  - Switching to one-shot while q != 0 finishes the current count, then stops.
- Pipelining:
  - Each slice keeps a registered "slice is zero" flag.
  - A slice decrements only when enabled and all lower slices' flags are set, so borrow is precomputed.
  - No arithmetic path may exceed NBITS_STAGE bits plus an NSTAGES-input AND.
  - Externally visible q must be exact every cycle; no pipeline skew is visible on o_q.
- Width: all arithmetic modulo 2^NBITS; no underflow is possible, because zero is handled explicitly.

Optional Feature:
- Macro FAST_COUNTER_CARRY_REG_EN.
- When defined: o_carry is registered, asserted one cycle after the qualifying enabled cycle, and not glitch-prone.
- When undefined: combinational o_carry, as above.
- All other outputs are unaffected.

Decomposition:
- Shared package fast_counter_pkg:
  - Mode constants MODE_AUTORELOAD = 1'b0 and MODE_ONESHOT = 1'b1.
  - Function computing NSTAGES.
- One sub-module, fast_counter_stage: NBITS_STAGE-bit slice with load, borrow-in enable, registered zero flag.
  - The top generates NSTAGES instances.

Test Plan:
- Reset, then check outputs: zero = 1, nzero = 0, q = 0, carry = 0, zpulse = 0.
- Auto-reload, 9-bit/4-bit stages, load 0x33, enable every other cycle:
  - q decrements 0x33..0.
  - carry once per 52 enables (104 clocks).
  - zpulse precedes each carry.
- Auto-reload, load 1, then 0 (with load pulse):
  - R = 1: q toggles 1,0; carry every 2nd enable.
  - R = 0: carry on every enable; zpulse never asserted.
- One-shot, load 0x3F, enable alternate cycles:
  - After 63 enables, q = 0, zpulse once.
  - Counter then stays 0; carry on each further enable, no reload.
- One-shot, load 5:
  - Single-cycle load: count to 0 after 5 enables.
  - Load held 10 cycles: q pinned at 5, no carry; counting resumes after release.
- One-shot, load 0: q = 0, zero = 1, zpulse not asserted; borrow across the slice boundary verified (load 0x100 -> 0xFF in one enable).
